// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Decode/issue pipeline slot in front of the EX-stage ALU.
//            Decodes opcode/funct into ALU op, shift amount and operands,
//            applies EX/MEM forwarding and load-use stall detection, and
//            holds the result in a registered valid/ready output slot.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        fwd_ex_en,
    input  logic        fwd_ex_load,
    input  logic [4:0]  fwd_ex_reg,
    input  logic [31:0] fwd_ex_data,
    input  logic        fwd_mem_en,
    input  logic [4:0]  fwd_mem_reg,
    input  logic [31:0] fwd_mem_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    output logic [4:0]  dest_reg,
    output logic        illegal,
    output logic [15:0] issue_count
);

    // ALU operation encodings
    localparam logic [3:0] c_ALU_OR  = 4'd0;
    localparam logic [3:0] c_ALU_AND = 4'd1;
    localparam logic [3:0] c_ALU_XOR = 4'd2;
    localparam logic [3:0] c_ALU_NOR = 4'd3;
    localparam logic [3:0] c_ALU_ADD = 4'd4;
    localparam logic [3:0] c_ALU_SUB = 4'd5;
    localparam logic [3:0] c_ALU_SLT = 4'd6;
    localparam logic [3:0] c_ALU_DIV = 4'd7;
    localparam logic [3:0] c_ALU_MUL = 4'd8;
    localparam logic [3:0] c_ALU_SRA = 4'd9;
    localparam logic [3:0] c_ALU_SRL = 4'd10;
    localparam logic [3:0] c_ALU_SLL = 4'd11;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt_field;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;

    assign w_opcode      = instr[31:26];
    assign w_rs          = instr[25:21];
    assign w_rt          = instr[20:16];
    assign w_rd          = instr[15:11];
    assign w_shamt_field = instr[10:6];
    assign w_funct       = instr[5:0];
    assign w_imm_sext    = {{16{instr[15]}}, instr[15:0]};
    assign w_imm_zext    = {16'h0000, instr[15:0]};

    // Register 0 always reads zero; EX result wins over MEM result.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  r,
        input logic [31:0] rf_val,
        input logic        ex_en,
        input logic [4:0]  ex_reg,
        input logic [31:0] ex_data,
        input logic        mem_en,
        input logic [4:0]  mem_reg,
        input logic [31:0] mem_data
    );
        logic [31:0] v;
        if (r == 5'd0)
            v = 32'h0;
        else if (ex_en && (ex_reg == r))
            v = ex_data;
        else if (mem_en && (mem_reg == r))
            v = mem_data;
        else
            v = rf_val;
        return v;
    endfunction

    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    assign w_rs_val = fwd_sel(w_rs, rs_data, fwd_ex_en, fwd_ex_reg, fwd_ex_data,
                              fwd_mem_en, fwd_mem_reg, fwd_mem_data);
    assign w_rt_val = fwd_sel(w_rt, rt_data, fwd_ex_en, fwd_ex_reg, fwd_ex_data,
                              fwd_mem_en, fwd_mem_reg, fwd_mem_data);

    // Decoded slot contents
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [3:0]  w_op;
    logic [4:0]  w_shamt;
    logic [4:0]  w_dest;
    logic        w_illegal;
    logic        w_is_shift;

    // Translate opcode/funct into ALU controls; unknown encodings fall through as illegal adds
    always_comb begin
        w_a        = w_rs_val;
        w_b        = 32'h0;
        w_op       = c_ALU_ADD;
        w_shamt    = 5'd0;
        w_dest     = 5'd0;
        w_illegal  = 1'b1;
        w_is_shift = 1'b0;
        if (w_opcode == c_OP_RTYPE) begin
            case (w_funct)
                6'h25:         begin w_op = c_ALU_OR;  w_illegal = 1'b0; end
                6'h24:         begin w_op = c_ALU_AND; w_illegal = 1'b0; end
                6'h26:         begin w_op = c_ALU_XOR; w_illegal = 1'b0; end
                6'h27:         begin w_op = c_ALU_NOR; w_illegal = 1'b0; end
                6'h20, 6'h21:  begin w_op = c_ALU_ADD; w_illegal = 1'b0; end
                6'h22, 6'h23:  begin w_op = c_ALU_SUB; w_illegal = 1'b0; end
                6'h2A:         begin w_op = c_ALU_SLT; w_illegal = 1'b0; end
                6'h1A:         begin w_op = c_ALU_DIV; w_illegal = 1'b0; end
                6'h18:         begin w_op = c_ALU_MUL; w_illegal = 1'b0; end
                6'h03:         begin w_op = c_ALU_SRA; w_illegal = 1'b0; w_is_shift = 1'b1; end
                6'h02:         begin w_op = c_ALU_SRL; w_illegal = 1'b0; w_is_shift = 1'b1; end
                6'h00:         begin w_op = c_ALU_SLL; w_illegal = 1'b0; w_is_shift = 1'b1; end
                default:       begin w_illegal = 1'b1; end
            endcase
            if (!w_illegal) begin
                w_b    = w_rt_val;
                w_dest = w_rd;
            end
            if (w_is_shift) begin
                w_a     = 32'h0;
                w_shamt = w_shamt_field;
            end
        end else begin
            case (w_opcode)
                c_OP_ADDI: begin w_op = c_ALU_ADD; w_b = w_imm_sext; w_dest = w_rt; w_illegal = 1'b0; end
                c_OP_ANDI: begin w_op = c_ALU_AND; w_b = w_imm_zext; w_dest = w_rt; w_illegal = 1'b0; end
                c_OP_ORI:  begin w_op = c_ALU_OR;  w_b = w_imm_zext; w_dest = w_rt; w_illegal = 1'b0; end
                c_OP_XORI: begin w_op = c_ALU_XOR; w_b = w_imm_zext; w_dest = w_rt; w_illegal = 1'b0; end
                c_OP_LW:   begin w_op = c_ALU_ADD; w_b = w_imm_sext; w_dest = w_rt; w_illegal = 1'b0; end
                c_OP_SW:   begin w_op = c_ALU_ADD; w_b = w_imm_sext; w_dest = 5'd0; w_illegal = 1'b0; end
                default:   begin w_illegal = 1'b1; end
            endcase
        end
    end

    // Load-use hazard: only sources the instruction actually reads can stall it
    logic w_uses_rs;
    logic w_uses_rt;
    logic w_stall;
    logic w_capture;

    assign w_uses_rs = !w_is_shift;
    assign w_uses_rt = (w_opcode == c_OP_RTYPE);
    assign w_stall   = fwd_ex_en && fwd_ex_load && (fwd_ex_reg != 5'd0) &&
                       ((w_uses_rs && (fwd_ex_reg == w_rs)) ||
                        (w_uses_rt && (fwd_ex_reg == w_rt)));

    logic        r_out_valid;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [3:0]  r_alu_op;
    logic [4:0]  r_alu_shamt;
    logic [4:0]  r_dest_reg;
    logic        r_illegal;
    logic [15:0] r_issue_count;

    assign in_ready  = !flush && !w_stall && (!r_out_valid || out_ready);
    assign w_capture = in_valid && in_ready;

    // Output slot: flush kills it, capture replaces it, consume empties it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_alu_a       <= 32'h0;
            r_alu_b       <= 32'h0;
            r_alu_op      <= 4'd0;
            r_alu_shamt   <= 5'd0;
            r_dest_reg    <= 5'd0;
            r_illegal     <= 1'b0;
            r_issue_count <= 16'd0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid   <= 1'b1;
            r_alu_a       <= w_a;
            r_alu_b       <= w_b;
            r_alu_op      <= w_op;
            r_alu_shamt   <= w_shamt;
            r_dest_reg    <= w_dest;
            r_illegal     <= w_illegal;
            r_issue_count <= r_issue_count + 16'd1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign alu_shamt   = r_alu_shamt;
    assign dest_reg    = r_dest_reg;
    assign illegal     = r_illegal;
    assign issue_count = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Scoreboard bench for alu_issue_stage with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_ex_en;
    logic        fwd_ex_load;
    logic [4:0]  fwd_ex_reg;
    logic [31:0] fwd_ex_data;
    logic        fwd_mem_en;
    logic [4:0]  fwd_mem_reg;
    logic [31:0] fwd_mem_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [4:0]  dest_reg;
    logic        illegal;
    logic [15:0] issue_count;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .fwd_ex_en    (fwd_ex_en),
        .fwd_ex_load  (fwd_ex_load),
        .fwd_ex_reg   (fwd_ex_reg),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_mem_en   (fwd_mem_en),
        .fwd_mem_reg  (fwd_mem_reg),
        .fwd_mem_data (fwd_mem_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_shamt    (alu_shamt),
        .dest_reg     (dest_reg),
        .illegal      (illegal),
        .issue_count  (issue_count)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [4:0]  dest;
        logic        ill;
        logic [15:0] cnt;
        logic        chk_a;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count = 16'd0;

    logic [5:0] fn_tab [10] = '{6'h25, 6'h24, 6'h26, 6'h27, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h1A, 6'h18};
    logic [3:0] op_tab [10] = '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd5,  4'd6,  4'd7,  4'd8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Present one instruction, wait (bounded) for acceptance, record its expected slot
    task automatic send(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] eop,
                        input logic [4:0] esh, input logic [4:0] edest, input logic eill,
                        input logic chka);
        int waited = 0;
        instr    = ins;
        rs_data  = rsd;
        rt_data  = rtd;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual in_ready 0 required 1 for instr %h", ins);
            in_valid = 1'b0;
        end else begin
            exp_count = exp_count + 16'd1;
            q.push_back('{a: ea, b: eb, op: eop, sh: esh, dest: edest, ill: eill,
                          cnt: exp_count, chk_a: chka});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: compare the slot each time EX consumes it (just before the edge)
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual out_valid 1 required empty slot");
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.chk_a) chk("alu_a", alu_a, mon_e.a);
                    chk("alu_b", alu_b, mon_e.b);
                    chk("alu_op", {28'd0, alu_op}, {28'd0, mon_e.op});
                    chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, mon_e.sh});
                    chk("dest_reg", {27'd0, dest_reg}, {27'd0, mon_e.dest});
                    chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
                    chk("issue_count", {16'd0, issue_count}, {16'd0, mon_e.cnt});
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        instr        = 32'h0;
        rs_data      = 32'h0;
        rt_data      = 32'h0;
        fwd_ex_en    = 1'b0;
        fwd_ex_load  = 1'b0;
        fwd_ex_reg   = 5'd0;
        fwd_ex_data  = 32'h0;
        fwd_mem_en   = 1'b0;
        fwd_mem_reg  = 5'd0;
        fwd_mem_data = 32'h0;
        flush        = 1'b0;
        out_ready    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_shamt", {27'd0, alu_shamt}, 32'd0);
        chk("rst_dest_reg", {27'd0, dest_reg}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_issue_count", {16'd0, issue_count}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // add $3,$1,$2
        @(negedge clk);
        send(32'h00221820, 32'd5, 32'd7, 32'd5, 32'd7, 4'd4, 5'd0, 5'd3, 1'b0, 1'b1);
        // addi $5,$0,-4 : rs field 0 reads zero regardless of rs_data
        @(negedge clk);
        send(32'h2005FFFC, 32'h123, 32'h0, 32'd0, 32'hFFFFFFFC, 4'd4, 5'd0, 5'd5, 1'b0, 1'b1);
        // ori $6,$1,0x8000 : zero-extended
        @(negedge clk);
        send(32'h34268000, 32'h10, 32'h0, 32'h10, 32'h00008000, 4'd0, 5'd0, 5'd6, 1'b0, 1'b1);

        // R-type funct table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, fn_tab[i]}, 32'd5, 32'd7,
                 32'd5, 32'd7, op_tab[i], 5'd0, 5'd3, 1'b0, 1'b1);
        end

        // Shifts: A forced to 0 even with nonzero rs
        @(negedge clk);
        send(32'h000220C3, 32'd0, 32'd9, 32'd0, 32'd9, 4'd9, 5'd3, 5'd4, 1'b0, 1'b1);
        @(negedge clk);
        send({6'd0, 5'd1, 5'd2, 5'd4, 5'd31, 6'h02}, 32'd5, 32'd9, 32'd0, 32'd9, 4'd10, 5'd31, 5'd4, 1'b0, 1'b1);

        // Remaining I-types
        @(negedge clk);
        send({6'h0C, 5'd1, 5'd6, 16'hF0F0}, 32'd5, 32'd0, 32'd5, 32'h0000F0F0, 4'd1, 5'd0, 5'd6, 1'b0, 1'b1);
        @(negedge clk);
        send({6'h0E, 5'd1, 5'd6, 16'h8001}, 32'd5, 32'd0, 32'd5, 32'h00008001, 4'd2, 5'd0, 5'd6, 1'b0, 1'b1);
        @(negedge clk);
        send({6'h23, 5'd1, 5'd7, 16'hFFF8}, 32'd5, 32'd0, 32'd5, 32'hFFFFFFF8, 4'd4, 5'd0, 5'd7, 1'b0, 1'b1);
        @(negedge clk);
        send(32'hAC220008, 32'd5, 32'd7, 32'd5, 32'd8, 4'd4, 5'd0, 5'd0, 1'b0, 1'b1);

        // Illegal encodings: funct 0x3F, variable shift sllv, unsupported opcode
        @(negedge clk);
        send(32'h0022183F, 32'd5, 32'd7, 32'd0, 32'd0, 4'd4, 5'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        send(32'h00221804, 32'd5, 32'd7, 32'd0, 32'd0, 4'd4, 5'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        send({6'h04, 5'd1, 5'd2, 16'h0010}, 32'd5, 32'd7, 32'd0, 32'd0, 4'd4, 5'd0, 5'd0, 1'b1, 1'b0);

        // Load-use stall: load into $2 blocks sll $4,$2,3
        @(negedge clk);
        fwd_ex_en   = 1'b1;
        fwd_ex_load = 1'b1;
        fwd_ex_reg  = 5'd2;
        fwd_ex_data = 32'h0;
        instr       = 32'h000220C0;
        rs_data     = 32'd0;
        rt_data     = 32'd9;
        in_valid    = 1'b1;
        #1;
        chk("stall_in_ready_c1", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("stall_in_ready_c2", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        fwd_ex_en   = 1'b0;
        fwd_ex_load = 1'b0;
        send(32'h000220C0, 32'd0, 32'd9, 32'd0, 32'd9, 4'd11, 5'd3, 5'd4, 1'b0, 1'b1);

        // Shift does not read rs: load into its rs must not stall
        @(negedge clk);
        fwd_ex_en   = 1'b1;
        fwd_ex_load = 1'b1;
        fwd_ex_reg  = 5'd1;
        fwd_ex_data = 32'h77;
        instr       = {6'd0, 5'd1, 5'd2, 5'd4, 5'd3, 6'h00};
        #1;
        chk("shift_rs_no_stall", {31'd0, in_ready}, 32'd1);
        send({6'd0, 5'd1, 5'd2, 5'd4, 5'd3, 6'h00}, 32'd5, 32'd9, 32'd0, 32'd9, 4'd11, 5'd3, 5'd4, 1'b0, 1'b1);
        // I-type does not read rt: load into its rt must not stall
        @(negedge clk);
        fwd_ex_reg = 5'd5;
        instr      = {6'h08, 5'd1, 5'd5, 16'h0001};
        rs_data    = 32'd5;
        #1;
        chk("itype_rt_no_stall", {31'd0, in_ready}, 32'd1);
        send({6'h08, 5'd1, 5'd5, 16'h0001}, 32'd5, 32'd0, 32'd5, 32'd1, 4'd4, 5'd0, 5'd5, 1'b0, 1'b1);
        fwd_ex_en   = 1'b0;
        fwd_ex_load = 1'b0;

        // Forwarding priority
        @(negedge clk);
        fwd_ex_en    = 1'b1;
        fwd_ex_reg   = 5'd1;
        fwd_ex_data  = 32'hAA;
        fwd_mem_en   = 1'b1;
        fwd_mem_reg  = 5'd1;
        fwd_mem_data = 32'hBB;
        send(32'h00221820, 32'd5, 32'd7, 32'hAA, 32'd7, 4'd4, 5'd0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        fwd_ex_en    = 1'b0;
        fwd_mem_reg  = 5'd2;
        fwd_mem_data = 32'h11;
        send(32'h00221820, 32'd5, 32'd7, 32'd5, 32'h11, 4'd4, 5'd0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        fwd_ex_en    = 1'b1;
        fwd_ex_reg   = 5'd0;
        fwd_ex_data  = 32'hDEAD;
        fwd_mem_reg  = 5'd0;
        fwd_mem_data = 32'hBEEF;
        send(32'h2005FFFC, 32'h123, 32'h0, 32'd0, 32'hFFFFFFFC, 4'd4, 5'd0, 5'd5, 1'b0, 1'b1);
        fwd_ex_en  = 1'b0;
        fwd_mem_en = 1'b0;

        // Backpressure: slot full, new instruction waits, fields stay put
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send(32'h00221820, 32'd5, 32'd7, 32'd5, 32'd7, 4'd4, 5'd0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        instr    = 32'h00221822;
        in_valid = 1'b1;
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_op_c1", {28'd0, alu_op}, 32'd4);
        @(negedge clk);
        #1;
        chk("bp_hold_op_c2", {28'd0, alu_op}, 32'd4);
        chk("bp_hold_a_c2", alu_a, 32'd5);
        out_ready = 1'b1;
        send(32'h00221822, 32'd5, 32'd7, 32'd5, 32'd7, 4'd5, 5'd0, 5'd3, 1'b0, 1'b1);
        chk("bp_replace_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_replace_op", {28'd0, alu_op}, 32'd5);

        // Flush with a full slot and a pending instruction
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 32'd5, 32'd7, 32'd5, 32'd7, 4'd0, 5'd0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        instr    = 32'h00221820;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_count", {16'd0, issue_count}, {16'd0, exp_count});
        void'(q.pop_back());
        @(negedge clk);
        out_ready = 1'b1;

        // Asynchronous reset with a live slot
        @(negedge clk);
        out_ready = 1'b0;
        send({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h26}, 32'd5, 32'd7, 32'd5, 32'd7, 4'd2, 5'd0, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("arst_dest_reg", {27'd0, dest_reg}, 32'd0);
        chk("arst_issue_count", {16'd0, issue_count}, 32'd0);
        q.delete();
        exp_count = 16'd0;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(32'h00221820, 32'd5, 32'd7, 32'd5, 32'd7, 4'd4, 5'd0, 5'd3, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
